fpganes_controller_test: RTL and testbench

FPGANES_CONTROLLER_TEST -- requirements
Module: fpganes_controller_test

---
 rtl/fpganes_controller_test.sv | 200 ++++++++++++++++++++
 tb/tb_fpganes_controller_test.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpganes_controller_test.sv
// NES controller poller: latches the pad at a fixed rate, shifts in eight buttons and
// shows the button byte and a 16-bit poll count on LEDs and 7-segment digits.
module fpganes_controller_test #(
  parameter int unsigned HALF_BIT    = 300,
  parameter int unsigned POLL_PERIOD = 833334
) (
  input  logic        CLOCK_50,
  input  logic        CLOCK2_50,
  input  logic        CLOCK3_50,
  input  logic        CLOCK4_50,
  input  logic [3:0]  KEY,
  inout  wire  [35:0] GPIO,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int unsigned TimerW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned CntW   = $clog2(2 * HALF_BIT) + 1;

  localparam logic [TimerW-1:0] TimerLast = TimerW'(POLL_PERIOD - 1);
  localparam logic [CntW-1:0]   LatchLast = CntW'(2 * HALF_BIT - 1);
  localparam logic [CntW-1:0]   HalfLast  = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StClkHi, StClkLo, StDone} state_e;

  logic              w_unused;
  logic [1:0]        r_rst_sync;
  logic              w_rst;
  logic [1:0]        r_data_sync;
  logic              w_sample;
  logic [TimerW-1:0] r_timer;
  logic              w_trigger;
  state_e            r_state;
  state_e            w_state_next;
  logic              w_phase_end;
  logic [CntW-1:0]   r_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [7:0]        r_buttons;
  logic [15:0]       r_poll_cnt;
  logic              r_toggle;
  logic              r_latch;
  logic              r_nes_clk;
  logic              r_busy;
  logic              w_latch_next;
  logic              w_nes_clk_next;
  logic              w_busy_next;

  assign w_unused = ^{CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY[3:1]};

  // Assert asynchronously, release on the second clock edge after KEY[0] drops.
  always_ff @(posedge CLOCK_50 or posedge KEY[0]) begin
    if (KEY[0]) r_rst_sync <= 2'b11;
    else        r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) r_data_sync <= 2'b11;
    else       r_data_sync <= {r_data_sync[0], GPIO[5]};
  end
  assign w_sample = ~r_data_sync[1];

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst)                    r_timer <= '0;
    else if (r_timer == TimerLast) r_timer <= '0;
    else                          r_timer <= r_timer + TimerW'(1);
  end
  assign w_trigger = (r_timer == '0);

  // State register
  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_phase_end  = 1'b0;
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_trigger) w_state_next = StLatch;
      end
      StLatch: begin
        w_phase_end = (r_cnt == LatchLast);
        if (w_phase_end) w_state_next = StClkHi;
      end
      StClkHi: begin
        w_phase_end = (r_cnt == HalfLast);
        if (w_phase_end) w_state_next = StClkLo;
      end
      StClkLo: begin
        w_phase_end = (r_cnt == HalfLast);
        if (w_phase_end) w_state_next = (r_bit_idx == 3'd7) ? StDone : StClkHi;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output decode, registered below so the pad-facing lines never glitch.
  always_comb begin
    w_latch_next   = (w_state_next == StLatch);
    w_nes_clk_next = (w_state_next == StClkHi);
    w_busy_next    = (w_state_next == StLatch) || (w_state_next == StClkHi) ||
                     (w_state_next == StClkLo);
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_latch   <= 1'b0;
      r_nes_clk <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_latch   <= w_latch_next;
      r_nes_clk <= w_nes_clk_next;
      r_busy    <= w_busy_next;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_buttons  <= '0;
      r_poll_cnt <= '0;
      r_toggle   <= 1'b0;
    end else begin
      if (w_phase_end || (r_state == StIdle) || (r_state == StDone)) r_cnt <= '0;
      else                                                          r_cnt <= r_cnt + CntW'(1);

      // First bit captured lands in bit 0 after all eight shifts.
      if (w_phase_end && ((r_state == StLatch) || (r_state == StClkLo))) begin
        r_shift <= {w_sample, r_shift[7:1]};
      end

      if (w_phase_end && (r_state == StLatch))      r_bit_idx <= 3'd1;
      else if (w_phase_end && (r_state == StClkLo)) r_bit_idx <= r_bit_idx + 3'd1;

      if (r_state == StDone) begin
        r_buttons  <= r_shift;
        r_toggle   <= ~r_toggle;
        r_poll_cnt <= r_poll_cnt + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < 36; i++) begin : g_gpio
    if (i == 1) begin : g_latch
      assign GPIO[i] = r_latch;
    end else if (i == 3) begin : g_clk
      assign GPIO[i] = r_nes_clk;
    end else if (i != 5) begin : g_hiz
      assign GPIO[i] = 1'bz;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign LEDR = {r_toggle, r_busy, r_buttons};
  assign HEX0 = seg7(r_buttons[3:0]);
  assign HEX1 = seg7(r_buttons[7:4]);
  assign HEX2 = seg7(r_poll_cnt[3:0]);
  assign HEX3 = seg7(r_poll_cnt[7:4]);
  assign HEX4 = seg7(r_poll_cnt[11:8]);
  assign HEX5 = seg7(r_poll_cnt[15:12]);

endmodule

// File: tb/tb_fpganes_controller_test.sv
// Directed bench: a behavioural NES pad answers the latch/clock lines and a queue of
// expected button bytes is checked each time a poll completes.
module tb_fpganes_controller_test;

  localparam int unsigned HalfBit    = 300;
  localparam int unsigned PollPeriod = 6000;

  logic        clk = 1'b0;
  logic        clk2 = 1'b0, clk3 = 1'b0, clk4 = 1'b0;
  logic [3:0]  key;
  wire  [35:0] gpio;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0]  hx [6];

  logic [7:0]  pad_buttons = 8'h00;
  logic [7:0]  pad_sr = 8'hFF;
  logic [7:0]  exp_q [$];
  int unsigned starts [$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  fpganes_controller_test #(
    .HALF_BIT   (HalfBit),
    .POLL_PERIOD(PollPeriod)
  ) dut (
    .CLOCK_50 (clk),
    .CLOCK2_50(clk2),
    .CLOCK3_50(clk3),
    .CLOCK4_50(clk4),
    .KEY      (key),
    .GPIO     (gpio),
    .LEDR     (ledr),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  // Pad model: parallel load on latch, shift on rising clock, active-low data.
  assign gpio[5] = pad_sr[0];
  always @(posedge gpio[1]) begin
    pad_sr = ~pad_buttons;
    starts.push_back(cyc);
  end
  always @(posedge gpio[3]) pad_sr = {1'b1, pad_sr[7:1]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    logic prev;
    prev = ledr[9];
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (ledr[9] !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_poll(input string tag);
    bit         ok;
    logic [7:0] exp;
    wait_done(ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    exp = 8'h00;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check({tag, "_buttons"}, 32'(ledr[7:0]), 32'(exp));
  endtask

  initial begin
    bit          found;
    int          lat_n, hi, lo, bad_busy, lat;
    int unsigned d0, d1;

    key = 4'hF;
    repeat (20) @(negedge clk);
    check("rst_ledr", 32'(ledr), 32'h0);
    check("rst_latch", 32'(gpio[1]), 32'h0);
    check("rst_nesclk", 32'(gpio[3]), 32'h0);
    for (int i = 0; i < 6; i++) check($sformatf("rst_hex%0d", i), 32'(hx[i]), 32'h40);

    // Poll 1: every button held, full waveform check.
    pad_buttons = 8'hFF;
    exp_q.push_back(8'hFF);
    key = 4'hE;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gpio[1] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("first_latch_seen", 32'(found), 32'd1);
    lat_n = 0;
    bad_busy = 0;
    while (gpio[1] === 1'b1 && lat_n < 2000) begin
      lat_n++;
      if (ledr[8] !== 1'b1) bad_busy++;
      @(negedge clk);
    end
    check("latch_len", 32'(lat_n), 32'(2 * HalfBit));
    for (int p = 0; p < 7; p++) begin
      hi = 0;
      while (gpio[3] === 1'b1 && hi < 2000) begin
        hi++;
        if (ledr[8] !== 1'b1 || gpio[1] !== 1'b0) bad_busy++;
        @(negedge clk);
      end
      lo = 0;
      while (gpio[3] === 1'b0 && ledr[8] === 1'b1 && lo < 2000) begin
        lo++;
        @(negedge clk);
      end
      check($sformatf("pulse%0d_hi", p), 32'(hi), 32'(HalfBit));
      check($sformatf("pulse%0d_lo", p), 32'(lo), 32'(HalfBit));
    end
    check("busy_during_poll", 32'(bad_busy), 32'd0);
    check("busy_clear_after_7", 32'(ledr[8]), 32'd0);
    check("no_8th_pulse", 32'(gpio[3]), 32'd0);
    check_poll("poll1");
    check("poll1_toggle", 32'(ledr[9]), 32'd1);
    check("poll1_hex0", 32'(hex0), 32'(7'b0001110));
    check("poll1_hex1", 32'(hex1), 32'(7'b0001110));
    check("poll1_hex2", 32'(hex2), 32'(7'b1111001));
    check("poll1_hex3", 32'(hex3), 32'(7'b1000000));
    check("poll1_hex4", 32'(hex4), 32'(7'b1000000));
    check("poll1_hex5", 32'(hex5), 32'(7'b1000000));

    // Poll 2: A and Start only.
    pad_buttons = 8'h09;
    exp_q.push_back(8'h09);
    check_poll("poll2");
    check("poll2_hex0", 32'(hex0), 32'(7'b0010000));
    check("poll2_hex1", 32'(hex1), 32'(7'b1000000));
    check("poll2_toggle", 32'(ledr[9]), 32'd0);
    check("poll2_hex2", 32'(hex2), 32'(seg_tab[2]));

    // Poll 3: mixed pattern, then the start spacing.
    pad_buttons = 8'hA5;
    exp_q.push_back(8'hA5);
    check_poll("poll3");
    check("poll3_hex0", 32'(hex0), 32'(seg_tab[5]));
    check("poll3_hex1", 32'(hex1), 32'(seg_tab[10]));
    check("poll3_hex2", 32'(hex2), 32'(7'b0110000));
    check("poll3_toggle", 32'(ledr[9]), 32'd1);
    check("starts_seen", 32'(starts.size() >= 3), 32'd1);
    d0 = 0;
    d1 = 0;
    if (starts.size() >= 3) begin
      d0 = starts[1] - starts[0];
      d1 = starts[2] - starts[1];
    end
    check("period_1_2", d0, PollPeriod);
    check("period_2_3", d1, PollPeriod);

    // Reset in the middle of a clock-high phase.
    pad_buttons = 8'h3C;
    found = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (gpio[3] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("poll4_clkhi_seen", 32'(found), 32'd1);
    repeat (10) @(negedge clk);
    check("poll4_clkhi_hold", 32'(gpio[3]), 32'd1);
    key = 4'hF;
    #1;
    check("midrst_nesclk", 32'(gpio[3]), 32'd0);
    check("midrst_latch", 32'(gpio[1]), 32'd0);
    check("midrst_ledr", 32'(ledr), 32'h0);
    repeat (5) @(negedge clk);
    check("midrst_hex0", 32'(hex0), 32'h40);
    check("midrst_hex2", 32'(hex2), 32'h40);
    exp_q.push_back(8'h3C);
    key = 4'hE;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gpio[1] === 1'b1) begin
        found = 1'b1;
        lat = i;
        break;
      end
    end
    check("restart_seen", 32'(found), 32'd1);
    check("restart_latency_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
    check_poll("poll5");
    check("poll5_hex2", 32'(hex2), 32'(seg_tab[1]));
    check("poll5_toggle", 32'(ledr[9]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
